pipe_skid_latch: RTL and testbench
==================================

PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (legal 1..256).
REQ-002 Parameter CNT_W, default 16, width of each performance counter (legal 4..32).
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into payload registers on reset and flush.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 state_i  input  2  latch command: 00 NORMAL, 01 STALL, 10 FLUSH, 11 treated as FLUSH.
REQ-007 in_valid  input  1  upstream offers in_data this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 in_ready  output  1  latch accepts in_data this cycle.
REQ-010 out_valid  output  1  out_data is valid for downstream.
REQ-011 out_data  output  WIDTH  head payload.
REQ-012 out_ready  input  1  downstream consumes out_data this cycle.
REQ-013 occupancy  output  2  entries held: 0, 1 or 2.
REQ-014 stall_cnt  output  CNT_W  saturating count of STALL cycles with occupancy > 0.
REQ-015 flush_cnt  output  CNT_W  saturating count of FLUSH cycles that discard at least one entry.
REQ-016 cnt_clr  input  1  synchronous clear of both counters.

Function
REQ-017 Storage is two entries: main register M (head, drives out_data) and skid register S; each has a valid bit; S valid implies M valid.
REQ-018 States: EMPTY (none valid), ONE (M only), TWO (M and S); occupancy = 0/1/2 respectively.
REQ-019 in_ready = (S not valid) AND (state_i is NORMAL or STALL); a function of registered state and state_i only, never of out_ready.
REQ-020 out_valid = (M valid) AND (state_i == NORMAL); STALL and FLUSH both hide the head.
REQ-021 in_fire = in_valid AND in_ready; out_fire = out_valid AND out_ready.
REQ-022 EMPTY: in_fire -> ONE, M <= in_data; else stay.
REQ-023 ONE: in_fire and out_fire -> ONE, M <= in_data; in_fire only -> TWO, S <= in_data; out_fire only -> EMPTY; neither -> stay.
REQ-024 TWO: out_fire -> ONE, M <= S; else stay (in_ready is 0 in TWO).
REQ-025 Ordering is strict FIFO; every accepted payload appears on out_data exactly once unless flushed; zero-latency bypass from in_data to out_data is not permitted (minimum latency 1 cycle).
REQ-026 STALL: output is hidden, but input is still accepted into free entries; payloads are not lost or reordered.
REQ-027 FLUSH has priority over all transfers: next edge -> EMPTY, both valid bits cleared, M and S loaded with RESET_VAL; in_ready = 0 and out_valid = 0 during the FLUSH cycle.
REQ-028 Registers without a transfer hold their value; out_data holds the last M value when out_valid is 0.
REQ-029 stall_cnt increments by 1 each cycle state_i == STALL and occupancy > 0; flush_cnt increments by 1 each FLUSH cycle with occupancy > 0.
REQ-030 Counters saturate at 2^CNT_W-1 and do not wrap.
REQ-031 cnt_clr forces both counters to 0 on the next edge, overriding any simultaneous increment.
REQ-032 Input changes during STALL or FLUSH create no X-propagation; illegal state_i 11 behaves identically to 10.

Reset
REQ-033 RST asserted: immediately, without waiting for CLK, state -> EMPTY, M and S = RESET_VAL, counters = 0; in_ready = 1 (if state_i is not FLUSH), out_valid = 0, occupancy = 0.
REQ-034 RST asserted mid-transfer discards all held payloads; the first edge after deassertion behaves as EMPTY.

Verification
REQ-035 Stream: NORMAL, out_ready = 1, in_valid = 1 with data 1,2,3,... for 10 cycles -> out_data 1..10 in order, one cycle behind input, occupancy stays 1.
REQ-036 Backpressure: accept 0xA then 0xB with out_ready = 0 -> occupancy 2, in_ready = 0; raise out_ready -> 0xA then 0xB, then EMPTY.
REQ-037 Stall: ONE holding 0x5, state_i = STALL 3 cycles, offer 0x6 -> out_valid = 0, 0x6 captured into S, stall_cnt = 3; return to NORMAL -> 0x5 then 0x6.
REQ-038 Flush: TWO, FLUSH 1 cycle with in_valid = 1 -> EMPTY, out_data = RESET_VAL, input not captured, flush_cnt = 1; FLUSH while EMPTY leaves flush_cnt unchanged.
REQ-039 Counter: CNT_W = 4, 20 STALL cycles with occupancy 1 -> stall_cnt = 15; cnt_clr with STALL -> 0.
REQ-040 Async reset: assert RST between edges while in TWO -> outputs reach reset values before the next CLK edge.

Source files
------------

// File: rtl/pipe_skid_latch.sv
// Two-entry pipeline latch (main + skid register) with STALL/FLUSH command input
// and saturating stall/flush performance counters.
module pipe_skid_latch #(
  parameter int                 WIDTH     = 32,
  parameter int                 CNT_W     = 16,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         state_i,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  input  logic               cnt_clr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  occ_e             r_state;
  occ_e             w_state_nxt;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_s;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_flush;
  logic w_stall;
  logic w_normal;
  logic w_in_fire;
  logic w_out_fire;
  logic w_occ_nz;
  logic w_ld_m_in;
  logic w_ld_m_s;
  logic w_ld_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Command 11 decodes as FLUSH because only the upper bit is inspected.
  assign w_flush    = state_i[1];
  assign w_stall    = (state_i == 2'b01);
  assign w_normal   = (state_i == 2'b00);
  assign w_occ_nz   = (r_state != ST_EMPTY);

  assign in_ready   = (r_state != ST_TWO) && !w_flush;
  assign out_valid  = w_occ_nz && w_normal;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  assign out_data   = r_m;
  assign occupancy  = r_state;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_ld_m_in   = 1'b0;
    w_ld_m_s    = 1'b0;
    w_ld_s      = 1'b0;
    if (w_flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_ld_m_in   = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_ld_m_in   = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = ST_TWO;
            w_ld_s      = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_state_nxt = ST_ONE;
            w_ld_m_s    = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload registers: head M feeds out_data directly, S only ever refills M.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_m <= RESET_VAL;
      r_s <= RESET_VAL;
    end else if (w_flush) begin
      r_m <= RESET_VAL;
      r_s <= RESET_VAL;
    end else begin
      if (w_ld_m_in) begin
        r_m <= in_data;
      end else if (w_ld_m_s) begin
        r_m <= r_s;
      end
      if (w_ld_s) begin
        r_s <= in_data;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && w_occ_nz) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
      if (w_flush && w_occ_nz) begin
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Bench for pipe_skid_latch: directed scenarios plus random traffic against a
// queue-based reference model of the two-entry latch.
module tb_pipe_skid_latch;

  localparam int          W    = 16;
  localparam int          CW   = 4;
  localparam int          CMAX = 15;
  localparam logic [W-1:0] RV  = 16'hDEAD;

  logic          CLK;
  logic          RST;
  logic [1:0]    state_i;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic          cnt_clr;

  pipe_skid_latch #(.WIDTH(W), .CNT_W(CW), .RESET_VAL(RV)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .state_i   (state_i),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .cnt_clr   (cnt_clr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last;
  int           m_sc;
  int           m_fc;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = RV;
    m_sc   = 0;
    m_fc   = 0;
  endtask

  // Called at a falling edge: drives inputs, checks outputs, advances model, waits one cycle.
  task automatic step(input logic [1:0] st, input logic iv, input logic [W-1:0] id,
                      input logic ordy, input logic clr);
    logic         fl;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_od;
    int           occ;
    state_i   = st;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    fl   = st[1];
    occ  = mq.size();
    e_ir = (occ < 2) && !fl;
    e_ov = (occ > 0) && (st == 2'b00);
    e_od = (occ > 0) ? mq[0] : m_last;
    check_val("in_ready",  64'(in_ready),  64'(e_ir));
    check_val("out_valid", 64'(out_valid), 64'(e_ov));
    check_val("out_data",  64'(out_data),  64'(e_od));
    check_val("occupancy", 64'(occupancy), 64'(occ));
    check_val("stall_cnt", 64'(stall_cnt), 64'(m_sc));
    check_val("flush_cnt", 64'(flush_cnt), 64'(m_fc));
    if (clr) begin
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (st == 2'b01 && occ > 0) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      if (fl && occ > 0)          m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
    end
    if (fl) begin
      mq.delete();
      m_last = RV;
    end else begin
      if (e_ov && ordy) void'(mq.pop_front());
      if (iv && e_ir)   mq.push_back(id);
      if (mq.size() > 0) m_last = mq[0];
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST       = 1'b1;
    state_i   = 2'b00;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    check_val("rst_in_ready",  64'(in_ready),  64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_occ",       64'(occupancy), 64'd0);
    check_val("rst_out_data",  64'(out_data),  64'(RV));
    check_val("rst_cnts",      64'({stall_cnt, flush_cnt}), 64'd0);
    RST = 1'b0;

    // Streaming with out_ready held high
    for (int i = 1; i <= 10; i++) step(2'b00, 1'b1, W'(i), 1'b1, 1'b0);
    check_val("stream_last", 64'(out_data), 64'd10);
    step(2'b00, 1'b0, '0, 1'b1, 1'b0);

    // Backpressure fills the skid register
    step(2'b00, 1'b1, 16'h000A, 1'b0, 1'b0);
    step(2'b00, 1'b1, 16'h000B, 1'b0, 1'b0);
    check_val("bp_occ", 64'(occupancy), 64'd2);
    check_val("bp_in_ready", 64'(in_ready), 64'd0);
    step(2'b00, 1'b1, 16'h00FF, 1'b0, 1'b0);
    step(2'b00, 1'b0, '0, 1'b1, 1'b0);
    check_val("bp_second", 64'(out_data), 64'h000B);
    step(2'b00, 1'b0, '0, 1'b1, 1'b0);
    step(2'b00, 1'b0, '0, 1'b0, 1'b0);

    // Stall still accepts input into the free entry
    step(2'b00, 1'b1, 16'h0005, 1'b0, 1'b1);
    step(2'b01, 1'b1, 16'h0006, 1'b1, 1'b0);
    step(2'b01, 1'b0, '0, 1'b1, 1'b0);
    step(2'b01, 1'b0, '0, 1'b1, 1'b0);
    check_val("stall_cnt3", 64'(stall_cnt), 64'd3);
    check_val("stall_occ",  64'(occupancy), 64'd2);
    step(2'b00, 1'b0, '0, 1'b1, 1'b0);
    step(2'b00, 1'b0, '0, 1'b1, 1'b0);
    check_val("stall_tail", 64'(out_data), 64'h0006);

    // Flush from TWO, then flush while empty
    step(2'b00, 1'b1, 16'h0011, 1'b0, 1'b1);
    step(2'b00, 1'b1, 16'h0022, 1'b0, 1'b0);
    step(2'b10, 1'b1, 16'h0077, 1'b1, 1'b0);
    check_val("flush_occ",  64'(occupancy), 64'd0);
    check_val("flush_data", 64'(out_data),  64'(RV));
    check_val("flush_cnt1", 64'(flush_cnt), 64'd1);
    step(2'b11, 1'b1, 16'h0088, 1'b1, 1'b0);
    check_val("flush_empty_cnt", 64'(flush_cnt), 64'd1);

    // Stall counter saturation and clear
    step(2'b00, 1'b1, 16'h0033, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(2'b01, 1'b0, '0, 1'b0, 1'b0);
    check_val("stall_sat", 64'(stall_cnt), 64'd15);
    step(2'b01, 1'b0, '0, 1'b0, 1'b1);
    check_val("stall_clr", 64'(stall_cnt), 64'd0);

    // Asynchronous reset while holding two entries
    step(2'b00, 1'b1, 16'h0044, 1'b0, 1'b0);
    state_i  = 2'b00;
    in_valid = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    check_val("arst_occ",       64'(occupancy), 64'd0);
    check_val("arst_out_valid", 64'(out_valid), 64'd0);
    check_val("arst_in_ready",  64'(in_ready),  64'd1);
    check_val("arst_out_data",  64'(out_data),  64'(RV));
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int       r;
      logic [1:0] st;
      r  = int'($urandom_range(0, 9));
      st = (r <= 5) ? 2'b00 : (r <= 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      step(st, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
